// File: rtl/matvec_stream_driver.sv
// Stream front/back end for the pipelined 3x3 matrix-vector multiplier: beat collection,
// credit-gated issue, latency tracking and a result FIFO. Optional job counter: MATVEC_JOB_CNT_EN.
`timescale 1ns/1ps

module matvec_stream_driver #(
  parameter int unsigned ELEM_W    = 3,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned PIPE_LAT  = 3,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*ELEM_W-1:0]   in_data,
  output logic [9*ELEM_W-1:0]   mm_matrix,
  output logic [3*ELEM_W-1:0]   mm_vector,
  input  logic [3*ACC_W-1:0]    mm_dot,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [3*ACC_W-1:0]    res_data
`ifdef MATVEC_JOB_CNT_EN
  ,
  output logic [15:0]           job_cnt
`endif
);

  localparam int unsigned BeatW = 3 * ELEM_W;
  localparam int unsigned ResW  = 3 * ACC_W;
  localparam int unsigned PtrW  = $clog2(OUT_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [2:0] {StVec, StR0, StR1, StR2, StIssue} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   vec_shadow_q;
  logic [3*BeatW-1:0] mat_shadow_q;
  logic [3*BeatW-1:0] mm_matrix_q;
  logic [BeatW-1:0]   mm_vector_q;
  logic [PIPE_LAT-1:0] lat_q, lat_d;
  logic [ResW-1:0]    mem_q [OUT_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;

  logic        beat_fire, credit_ok, issue, push, pop;
  int unsigned inflight;

  assign in_ready  = rst_n && (state_q != StIssue);
  assign beat_fire = in_valid && in_ready;
  assign push      = lat_q[PIPE_LAT-1];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem_q[rd_ptr_q];
  assign mm_matrix = mm_matrix_q;
  assign mm_vector = mm_vector_q;

  // A pop in the same cycle is ignored, so credit is conservative by one slot at most.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      inflight += 32'(lat_q[i]);
    end
    credit_ok = (32'(count_q) + inflight) < OUT_DEPTH;
    issue     = (state_q == StIssue) && credit_ok;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StVec:   if (beat_fire) state_d = StR0;
      StR0:    if (beat_fire) state_d = StR1;
      StR1:    if (beat_fire) state_d = StR2;
      StR2:    if (beat_fire) state_d = StIssue;
      StIssue: if (credit_ok) state_d = StVec;
      default: state_d = StVec;
    endcase
  end

  always_comb begin
    lat_d    = '0;
    lat_d[0] = issue;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StVec;
      vec_shadow_q <= '0;
      mat_shadow_q <= '0;
      mm_matrix_q  <= '0;
      mm_vector_q  <= '0;
      lat_q        <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      // Shadow loading leaves the multiplier operands untouched until issue.
      if (beat_fire) begin
        unique case (state_q)
          StVec:   vec_shadow_q                  <= in_data;
          StR0:    mat_shadow_q[0*BeatW +: BeatW] <= in_data;
          StR1:    mat_shadow_q[1*BeatW +: BeatW] <= in_data;
          StR2:    mat_shadow_q[2*BeatW +: BeatW] <= in_data;
          default: ;
        endcase
      end
      if (issue) begin
        mm_matrix_q <= mat_shadow_q;
        mm_vector_q <= vec_shadow_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= mm_dot;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef MATVEC_JOB_CNT_EN
  logic [15:0] job_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt_q <= '0;
    end else if (push) begin
      job_cnt_q <= job_cnt_q + 16'd1;
    end
  end

  assign job_cnt = job_cnt_q;
`endif

endmodule
